// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the fetch-queue entry type.
package riscv_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0]   PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries with push/pop/flush and occupancy count.
module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: SRAM issue, in-flight kill, prefetch queue.
// Optional FETCH_BYPASS_EN forwards an SRAM response straight to decode when the queue is empty.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              I_MEM_CSN,
  output logic [XLEN-1:0]   I_MEM_ADDR,
  input  logic [INST_W-1:0] I_MEM_DI,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] PC_MASK  = ~32'h3;
  localparam logic [XLEN-1:0] RESET_AL = RESET_PC & PC_MASK;

  logic [XLEN-1:0] fetch_pc, addr_q, inflight_pc;
  logic            inflight, resp_valid, pop, issue;
  logic            q_push, q_pop, q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    head, resp, out_entry;
  int              occ;

  assign resp       = '{pc: inflight_pc, inst: I_MEM_DI};
  assign resp_valid = inflight & ~redirect_valid;
  assign pop        = out_valid & out_ready;

`ifdef FETCH_BYPASS_EN
  // Bypass keys off inflight, not resp_valid, so out_valid never depends on redirect_valid.
  logic bypass;
  assign bypass    = q_empty & inflight;
  assign out_valid = ~q_empty | bypass;
  assign out_entry = bypass ? resp : head;
  assign q_pop     = pop & ~q_empty;
  assign q_push    = resp_valid & ~(bypass & out_ready);
`else
  assign out_valid = ~q_empty;
  assign out_entry = head;
  assign q_pop     = pop;
  assign q_push    = resp_valid;
`endif

  assign out_inst = out_entry.inst;
  assign out_pc   = out_entry.pc;

  // Only issue when the response is guaranteed a slot after this cycle's pop.
  always_comb begin
    occ   = int'(q_count) + int'(inflight) - int'(pop);
    issue = ~RST & ~redirect_valid & (occ < DEPTH);
  end

  assign I_MEM_CSN  = ~issue;
  assign I_MEM_ADDR = issue ? fetch_pc : addr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_AL;
      addr_q      <= RESET_AL;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & PC_MASK;
      end else if (issue) begin
        fetch_pc    <= fetch_pc + PC_STEP;
        addr_q      <= fetch_pc;
        inflight_pc <= fetch_pc;
      end
    end
  end

  riscv_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (resp),
    .pop       (q_pop),
    .head      (head),
    .count     (q_count),
    .empty     (q_empty)
  );
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: directed phases push expected pcs, monitors compare pops.
module tb_riscv_fetch_unit;
  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  localparam logic [31:0] INST_KEY = 32'h5A5A_0013;

  logic        CLK, RST;
  logic        I_MEM_CSN, out_valid, out_ready, redirect_valid;
  logic [31:0] I_MEM_ADDR, I_MEM_DI, redirect_pc, out_inst, out_pc;
  logic        csn2, out_valid2, out_ready2, redirect_valid2;
  logic [31:0] addr2, di2, redirect_pc2, out_inst2, out_pc2;

  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2[$];

  riscv_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST), .I_MEM_CSN(I_MEM_CSN), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_DI(I_MEM_DI),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc));

  riscv_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut2 (
    .CLK(CLK), .RST(RST), .I_MEM_CSN(csn2), .I_MEM_ADDR(addr2), .I_MEM_DI(di2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_inst(out_inst2), .out_pc(out_pc2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM models: word at address a holds a ^ INST_KEY, one-cycle latency.
  initial begin I_MEM_DI = '0; di2 = '0; end
  always @(posedge CLK) if (!I_MEM_CSN) I_MEM_DI <= I_MEM_ADDR ^ INST_KEY;
  always @(posedge CLK) if (!csn2) di2 <= addr2 ^ INST_KEY;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Monitor for the main DUT: every accepted instruction must match the scoreboard front.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_pc", out_pc, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_inst", out_inst, e ^ INST_KEY);
      end
    end
  end

  // Monitor for the RESET_PC wrap instance: first four instructions only.
  always @(negedge CLK) begin
    if (!RST && out_valid2 && out_ready2 && exp2.size() > 0) begin
      logic [31:0] e;
      e = exp2.pop_front();
      check("wrap_out_pc", out_pc2, e);
      check("wrap_out_inst", out_inst2, e ^ INST_KEY);
    end
  end

  initial begin
    RST = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = '0;
    for (int i = 0; i < 40; i++) exp_q.push_back(32'(i * 4));
    exp2.push_back(32'hFFFF_FFF8); exp2.push_back(32'hFFFF_FFFC);
    exp2.push_back(32'h0000_0000); exp2.push_back(32'h0000_0004);

    // Reset state
    repeat (3) tick();
    @(negedge CLK);
    check("rst_csn", {31'b0, I_MEM_CSN}, 32'd1);
    check("rst_addr", I_MEM_ADDR, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);

    // Reset release latency, then back-to-back streaming
    tick(); RST = 1'b0;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge CLK);
      check("boot_valid", {31'b0, out_valid}, {31'b0, n == LAT});
      if (n == 1) begin
        check("boot_csn", {31'b0, I_MEM_CSN}, 32'd0);
        check("boot_addr", I_MEM_ADDR, 32'h0);
      end
    end
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      check("stream_no_bubble", {31'b0, out_valid}, 32'd1);
    end

    // Back-pressure: queue fills, issue stops, drain keeps order
    tick(); out_ready = 1'b0;
    repeat (10) tick();
    @(negedge CLK);
    check("full_csn", {31'b0, I_MEM_CSN}, 32'd1);
    check("full_count", 32'(u_dut.u_queue.count), 32'(DEPTH));
    check("full_valid", {31'b0, out_valid}, 32'd1);
    tick(); out_ready = 1'b1;
    repeat (6) tick();

    // Redirect to unaligned target while a read is in flight
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick(); redirect_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    for (int n = 1; n <= LAT; n++) begin
      @(negedge CLK);
      check("redir_valid", {31'b0, out_valid}, {31'b0, n == LAT});
      if (n == 1) begin
        check("redir_csn", {31'b0, I_MEM_CSN}, 32'd0);
        check("redir_addr", I_MEM_ADDR, 32'h0000_0100);
      end
      if (n == LAT) check("redir_first_pc", out_pc, 32'h0000_0100);
    end
    repeat (4) tick();

    // Redirect together with a pop on a full queue; target also exercises pc wrap
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) exp_q.push_back(32'hFFFF_FFF8 + 32'(i * 4));
    @(negedge CLK);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_count", 32'(u_dut.u_queue.count), 32'd0);
    repeat (8) tick();

    @(negedge CLK);
    check("wrap_inst_seen", 32'(exp2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
